oflow_best_match_selector: RTL and testbench
============================================

Name: oflow_best_match_selector

Overview:
- Sits downstream of oflow_similarity_metric and consumes its valid/score/id result stream.
- For one current object, collects the scores against N previous-frame objects and tracks the best (lowest score) and second-best candidates.
- Reports the winning id, and reports whether the match passes a programmable acceptance threshold.
- Feeds the ID-assignment stage; a new current object is started with a start pulse.

Parameters:
- SCORE_LEN, 16, width of score_in and the score outputs (matches the metric's score width).
- ID_LEN, 7, width of id_in and the id outputs.
- CNT_LEN, 7, width of num_prev and the internal candidate counter (up to 2^CNT_LEN-1 previous objects).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_N  in  1  synchronous, active-high reset: reset when 1, sampled on rising clk.
- start  in  1  one-cycle pulse that begins collection for a new current object.
- num_prev  in  CNT_LEN  number of scores to expect; sampled only on the start cycle.
- threshold  in  SCORE_LEN  acceptance limit; sampled on the start cycle.
- valid_in  in  1  score_in/id_in valid this cycle (driven by the metric's valid).
- score_in  in  SCORE_LEN  similarity cost; lower means a better match.
- id_in  in  ID_LEN  id of the previous object that produced score_in.
- busy  out  1  high while in COLLECT.
- done  out  1  one-cycle pulse when the result is final.
- best_score  out  SCORE_LEN  lowest score seen.
- best_id  out  ID_LEN  id of best_score.
- second_score  out  SCORE_LEN  second-lowest score seen.
- second_id  out  ID_LEN  id of second_score.
- match_found  out  1  1 when at least one score was received and best_score <= threshold.
- stray_err  out  1  sticky flag: valid_in arrived while not in COLLECT.

Behaviour:
- Reset (reset_N=1): state=IDLE, busy=0, done=0, match_found=0, stray_err=0, best_score=second_score=all-ones, best_id=second_id=0, counter=0. Reset overrides all other inputs, including mid-COLLECT.
- State IDLE:
  - On start: latch num_prev and threshold, clear the counter, set best/second to all-ones with ids 0, clear match_found.
  - Next state is COLLECT, or DONE if num_prev==0.
- State COLLECT (busy=1): each valid_in cycle is one candidate, and the counter increments.
  - If score_in < best_score: second <= best (score and id), best <= {score_in, id_in}.
  - Else if score_in < second_score: second <= {score_in, id_in}.
  - Ties use strict compares, so the earlier-arriving candidate keeps priority.
  - When the accepted candidate is number num_prev (counter == num_prev-1 before the increment), next state is DONE.
  - Cycles with valid_in=0 are idle waits; there is no timeout.
- State DONE:
  - done=1 for exactly this one cycle; match_found <= (counter != 0) && (best_score <= threshold).
  - Then go to IDLE.
- Result outputs hold their values after DONE until the next start.
- Latency: done is asserted on the cycle after the rising edge that accepts the final valid_in. For num_prev==0, done is asserted on the cycle after start, with match_found=0 and best_id=0.
- start while in COLLECT: aborts the current collection with no done pulse and restarts it exactly as from IDLE, using the new num_prev and threshold.
- start in the DONE cycle: accepted; the restart happens and done still pulses that cycle.
- valid_in coincident with start: that valid is ignored, not counted, and sets stray_err.
- valid_in in IDLE or DONE: ignored and sets stray_err. stray_err clears only on reset.
- Comparisons are unsigned; no arithmetic widening is needed.

Test Plan:
- Basic select: reset, start with num_prev=3, threshold=100; feed (50,id12), (30,id5), (70,id9) on consecutive cycles. Expect done one cycle after the third valid, best=30/5, second=50/12, match_found=1.
- Gapped valids and tie: num_prev=2; feed (40,id3), two idle cycles, then (40,id7). Expect best=40/3, second=40/7, busy high throughout, done one cycle after id7.
- Threshold reject: num_prev=1, threshold=20; feed (21,id4). Expect best=21/4, match_found=0. Repeat with threshold=21 and expect match_found=1.
- Zero candidates: start with num_prev=0. Expect done on the next cycle, match_found=0, best_score=all-ones, best_id=0, busy never asserted.
- Abort/restart: num_prev=3; feed one score (10,id1), then pulse start with num_prev=1 and feed (60,id2). Expect a single done, best=60/2, and no trace of id1.
- Stray and reset: valid_in while in IDLE sets stray_err=1; assert reset_N mid-COLLECT. Expect all outputs at reset values on the next cycle and no done pulse.

Source files
------------

// File: rtl/oflow_best_match_selector.sv
// oflow_best_match_selector
//   Consumes the valid/score/id stream from oflow_similarity_metric for one
//   current object and tracks the best (lowest) and second-best candidates
//   among num_prev previous-frame objects.
//
// Ports:
//   clk          system clock, all state updates on rising edge
//   reset_N      synchronous active-high reset
//   start        one-cycle pulse, begins collection for a new current object
//   num_prev     number of scores to expect (sampled on start)
//   threshold    acceptance limit for best_score (sampled on start)
//   valid_in     score_in/id_in valid this cycle
//   score_in     similarity cost, lower is better
//   id_in        id of the previous object that produced score_in
//   busy         high while collecting
//   done         one-cycle pulse when the result is final
//   best_score   lowest score seen, best_id its id
//   second_score second-lowest score seen, second_id its id
//   match_found  at least one score received and best_score <= threshold
//   stray_err    sticky: valid_in arrived while not collecting
module oflow_best_match_selector #(
    parameter int SCORE_LEN = 16,
    parameter int ID_LEN    = 7,
    parameter int CNT_LEN   = 7
) (
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 start,
    input  logic [CNT_LEN-1:0]   num_prev,
    input  logic [SCORE_LEN-1:0] threshold,
    input  logic                 valid_in,
    input  logic [SCORE_LEN-1:0] score_in,
    input  logic [ID_LEN-1:0]    id_in,
    output logic                 busy,
    output logic                 done,
    output logic [SCORE_LEN-1:0] best_score,
    output logic [ID_LEN-1:0]    best_id,
    output logic [SCORE_LEN-1:0] second_score,
    output logic [ID_LEN-1:0]    second_id,
    output logic                 match_found,
    output logic                 stray_err
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    localparam logic [CNT_LEN-1:0] CNT_ONE = CNT_LEN'(1);

    state_t               state;
    logic [CNT_LEN-1:0]   cnt;
    logic [CNT_LEN-1:0]   num_lat;
    logic [SCORE_LEN-1:0] thr_lat;

    always_ff @(posedge clk) begin
        if (reset_N) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            match_found  <= 1'b0;
            stray_err    <= 1'b0;
            best_score   <= '1;
            best_id      <= '0;
            second_score <= '1;
            second_id    <= '0;
            cnt          <= '0;
            num_lat      <= '0;
            thr_lat      <= '0;
        end else begin
            done <= 1'b0;

            // A valid coinciding with start is never counted, so it is stray too.
            if (valid_in && (start || state != COLLECT)) begin
                stray_err <= 1'b1;
            end

            // start restarts from any state; in COLLECT it aborts without done.
            if (start) begin
                num_lat      <= num_prev;
                thr_lat      <= threshold;
                cnt          <= '0;
                best_score   <= '1;
                best_id      <= '0;
                second_score <= '1;
                second_id    <= '0;
                match_found  <= 1'b0;
                if (num_prev == '0) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= COLLECT;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                    end
                    COLLECT: begin
                        if (valid_in) begin
                            cnt <= cnt + CNT_ONE;
                            // Strict compares keep the earlier candidate on ties.
                            if (score_in < best_score) begin
                                second_score <= best_score;
                                second_id    <= best_id;
                                best_score   <= score_in;
                                best_id      <= id_in;
                            end else if (score_in < second_score) begin
                                second_score <= score_in;
                                second_id    <= id_in;
                            end
                            if (cnt == num_lat - CNT_ONE) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        match_found <= (cnt != '0) && (best_score <= thr_lat);
                        state       <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oflow_best_match_selector.sv
module tb_oflow_best_match_selector;

    logic        clk = 1'b0;
    logic        reset_N;
    logic        start;
    logic [6:0]  num_prev;
    logic [15:0] threshold;
    logic        valid_in;
    logic [15:0] score_in;
    logic [6:0]  id_in;
    logic        busy;
    logic        done;
    logic [15:0] best_score;
    logic [6:0]  best_id;
    logic [15:0] second_score;
    logic [6:0]  second_id;
    logic        match_found;
    logic        stray_err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    oflow_best_match_selector #(
        .SCORE_LEN(16),
        .ID_LEN   (7),
        .CNT_LEN  (7)
    ) dut (
        .clk         (clk),
        .reset_N     (reset_N),
        .start       (start),
        .num_prev    (num_prev),
        .threshold   (threshold),
        .valid_in    (valid_in),
        .score_in    (score_in),
        .id_in       (id_in),
        .busy        (busy),
        .done        (done),
        .best_score  (best_score),
        .best_id     (best_id),
        .second_score(second_score),
        .second_id   (second_id),
        .match_found (match_found),
        .stray_err   (stray_err)
    );

    always #5 clk = ~clk;

    // Count done pulses mid-cycle, away from the active edge.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n, input int thr);
        start     = 1'b1;
        num_prev  = 7'(n);
        threshold = 16'(thr);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int sc, input int id);
        valid_in = 1'b1;
        score_in = 16'(sc);
        id_in    = 7'(id);
        tick();
        valid_in = 1'b0;
    endtask

    // Reference: best is the earliest minimum; second is the earliest minimum
    // of the remaining candidates; both start at all-ones / id 0.
    task automatic model(input int n, input int sc[8], input int id[8], input int thr,
                         output int bs, output int bi, output int ss, output int si,
                         output int mf);
        int bidx;
        bs = 16'hFFFF; bi = 0; bidx = -1;
        for (int i = 0; i < n; i++)
            if (sc[i] < bs) begin bs = sc[i]; bi = id[i]; bidx = i; end
        ss = 16'hFFFF; si = 0;
        for (int i = 0; i < n; i++)
            if (i != bidx && sc[i] < ss) begin ss = sc[i]; si = id[i]; end
        mf = (n != 0 && bs <= thr) ? 1 : 0;
    endtask

    task automatic do_reset();
        reset_N = 1'b1;
        tick();
        tick();
        reset_N = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, done, match_found, stray_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, match_found, stray_err});
        end
        total++;
        if ({best_score, best_id, second_score, second_id} !== {16'hFFFF, 7'd0, 16'hFFFF, 7'd0}) begin
            bad++; $display("FAIL reset_results got=%h/%0d %h/%0d want=ffff/0 ffff/0",
                            best_score, best_id, second_score, second_id);
        end
    endtask

    task automatic test_basic();
        int d0;
        pulse_start(3, 100);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        d0 = done_cnt;
        feed(50, 12);
        feed(30, 5);
        total++;
        if (done !== 1'b0 || done_cnt != d0) begin
            bad++; $display("FAIL basic_early_done got=%b want=0", done);
        end
        feed(70, 9);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done); end
        tick();
        total++;
        if ({best_score, best_id, second_score, second_id, match_found} !== {16'd30, 7'd5, 16'd50, 7'd12, 1'b1}) begin
            bad++; $display("FAIL basic_result got=%0d/%0d %0d/%0d mf=%b want=30/5 50/12 mf=1",
                            best_score, best_id, second_score, second_id, match_found);
        end
    endtask

    task automatic test_gap_tie();
        pulse_start(2, 100);
        feed(40, 3);
        tick();
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL gap_busy got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        tick();
        feed(40, 7);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL gap_done got=%b want=1", done); end
        tick();
        total++;
        if ({best_score, best_id, second_score, second_id} !== {16'd40, 7'd3, 16'd40, 7'd7}) begin
            bad++; $display("FAIL gap_tie got=%0d/%0d %0d/%0d want=40/3 40/7",
                            best_score, best_id, second_score, second_id);
        end
    endtask

    task automatic test_threshold();
        pulse_start(1, 20);
        feed(21, 4);
        tick();
        total++;
        if ({best_score, best_id, match_found} !== {16'd21, 7'd4, 1'b0}) begin
            bad++; $display("FAIL thr_reject got=%0d/%0d mf=%b want=21/4 mf=0", best_score, best_id, match_found);
        end
        pulse_start(1, 21);
        feed(21, 4);
        tick();
        total++;
        if (match_found !== 1'b1) begin
            bad++; $display("FAIL thr_accept got mf=%b want=1", match_found);
        end
    endtask

    task automatic test_zero();
        pulse_start(0, 100);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_done got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        tick();
        total++;
        if ({match_found, best_score, best_id, busy} !== {1'b0, 16'hFFFF, 7'd0, 1'b0}) begin
            bad++; $display("FAIL zero_result got mf=%b %h/%0d busy=%b want mf=0 ffff/0 busy=0",
                            match_found, best_score, best_id, busy);
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        pulse_start(3, 100);
        feed(10, 1);
        pulse_start(1, 100);
        total++;
        if (done_cnt != d0 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_nodone got pulses=%0d busy=%b want 0 busy=1", done_cnt - d0, busy);
        end
        feed(60, 2);
        tick();
        total++;
        if ({best_score, best_id, second_score, second_id, match_found} !== {16'd60, 7'd2, 16'hFFFF, 7'd0, 1'b1}) begin
            bad++; $display("FAIL abort_result got=%0d/%0d %h/%0d mf=%b want=60/2 ffff/0 mf=1",
                            best_score, best_id, second_score, second_id, match_found);
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++; $display("FAIL abort_pulses got=%0d want=1", done_cnt - d0);
        end
    endtask

    task automatic test_stray_reset();
        int d0;
        total++;
        if (stray_err !== 1'b0) begin bad++; $display("FAIL stray_pre got=%b want=0", stray_err); end
        feed(5, 5);
        total++;
        if (stray_err !== 1'b1) begin bad++; $display("FAIL stray_idle got=%b want=1", stray_err); end
        pulse_start(3, 100);
        feed(5, 9);
        d0 = done_cnt;
        reset_N  = 1'b1;
        valid_in = 1'b1; score_in = 16'd1; id_in = 7'd1;
        tick();
        valid_in = 1'b0;
        reset_N  = 1'b0;
        total++;
        if ({busy, done, match_found, stray_err, best_score, best_id, second_score, second_id} !==
            {4'b0000, 16'hFFFF, 7'd0, 16'hFFFF, 7'd0}) begin
            bad++; $display("FAIL midreset got flags=%b %h/%0d %h/%0d", {busy, done, match_found, stray_err},
                            best_score, best_id, second_score, second_id);
        end
        tick();
        tick();
        total++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_nodone got pulses=%0d busy=%b want 0 busy=0", done_cnt - d0, busy);
        end
        // Valid coincident with start is ignored and flagged.
        valid_in = 1'b1; score_in = 16'd1; id_in = 7'd9;
        pulse_start(1, 100);
        valid_in = 1'b0;
        feed(50, 3);
        tick();
        total++;
        if ({best_score, best_id, stray_err} !== {16'd50, 7'd3, 1'b1}) begin
            bad++; $display("FAIL start_valid got=%0d/%0d stray=%b want=50/3 stray=1", best_score, best_id, stray_err);
        end
    endtask

    task automatic test_random();
        int sc[8];
        int id[8];
        int n, thr, bs, bi, ss, si, mf;
        for (int t = 0; t < 40; t++) begin
            n   = $urandom_range(1, 8);
            thr = $urandom_range(0, 60);
            for (int i = 0; i < 8; i++) begin
                sc[i] = $urandom_range(0, 60);
                id[i] = $urandom_range(0, 127);
            end
            model(n, sc, id, thr, bs, bi, ss, si, mf);
            pulse_start(n, thr);
            for (int i = 0; i < n; i++) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
                feed(sc[i], id[i]);
                if (i < n - 1) begin
                    total++;
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        bad++; $display("FAIL rand_mid t=%0d i=%0d got busy=%b done=%b want 1 0", t, i, busy, done);
                    end
                end
            end
            total++;
            if (done !== 1'b1) begin bad++; $display("FAIL rand_done t=%0d got=%b want=1", t, done); end
            tick();
            total++;
            if (best_score !== 16'(bs) || best_id !== 7'(bi) || second_score !== 16'(ss) ||
                second_id !== 7'(si) || match_found !== 1'(mf)) begin
                bad++; $display("FAIL rand_result t=%0d got=%0d/%0d %0d/%0d mf=%b want=%0d/%0d %0d/%0d mf=%0d",
                                t, best_score, best_id, second_score, second_id, match_found, bs, bi, ss, si, mf);
            end
        end
    endtask

    initial begin
        reset_N = 1'b1; start = 1'b0; num_prev = '0; threshold = '0;
        valid_in = 1'b0; score_in = '0; id_in = '0;
        test_reset();
        test_basic();
        test_gap_tie();
        test_threshold();
        test_zero();
        test_abort();
        test_random();
        test_stray_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
